// File: rtl/count_wrap_monitor_if.sv
// Bundle for count_wrap_monitor: counter sample, snapshot request, capture handshake and status.
// The master side is the counter plus snapshot consumer; the slave side is the monitor.
interface count_wrap_monitor_if #(
   parameter int WRAP_W = 5
);
   logic [2:0]        Q_IN;
   logic              SNAP;
   logic              CAP_READY;
   logic              TC;
   logic [WRAP_W-1:0] WRAP_CNT;
   logic              OVF;
   logic              CAP_VALID;
   logic [WRAP_W+2:0] CAP_DATA;
   logic              ERR;

   modport master (
      output Q_IN, SNAP, CAP_READY,
      input  TC, WRAP_CNT, OVF, CAP_VALID, CAP_DATA, ERR
   );

   modport slave (
      input  Q_IN, SNAP, CAP_READY,
      output TC, WRAP_CNT, OVF, CAP_VALID, CAP_DATA, ERR
   );
endinterface

// File: rtl/count_wrap_monitor.sv
// Watches a 3-bit counter: terminal-count pulse, saturating wrap count, snapshot handshake.
// Optional macro COUNT_STEP_CHECK_EN adds a sticky illegal-step flag on ERR.
module count_wrap_monitor #(
   parameter int WRAP_W = 5,
   parameter int TC_VAL = 7
) (
   input logic                 CK,
   input logic                 RST,
   input logic                 VDD,
   count_wrap_monitor_if.slave bus
);
   localparam logic [0:0]        IDLE     = 1'b0;
   localparam logic [0:0]        HOLD     = 1'b1;
   localparam logic [2:0]        TC_Q     = 3'(TC_VAL);
   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

   logic [0:0]        state;
   logic [2:0]        q_s;
   logic              primed;
   logic              tc_r;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              ovf;
   logic [WRAP_W+2:0] cap_data;

   logic              tc_hit;
   logic              wrap_hit;
   logic              ovf_set;
   logic [WRAP_W-1:0] wrap_nxt;

   // Events compare the previous sample against the live input; nothing fires until primed.
   assign tc_hit   = primed && (bus.Q_IN == TC_Q) && (q_s != TC_Q);
   assign wrap_hit = primed && (q_s == 3'd7) && (bus.Q_IN == 3'd0);
   assign ovf_set  = wrap_hit && (wrap_cnt == WRAP_MAX);
   assign wrap_nxt = (wrap_hit && !ovf_set) ? wrap_cnt + 1'b1 : wrap_cnt;

   always_ff @(posedge CK) begin
      if (RST) begin
         state    <= IDLE;
         q_s      <= '0;
         primed   <= 1'b0;
         tc_r     <= 1'b0;
         wrap_cnt <= '0;
         ovf      <= 1'b0;
         cap_data <= '0;
      end else begin
         q_s      <= bus.Q_IN;
         primed   <= 1'b1;
         tc_r     <= tc_hit;
         wrap_cnt <= wrap_nxt;
         if (ovf_set)
            ovf <= 1'b1;
         case (state)
            IDLE: begin
               // Snapshot carries the wrap count as updated on this same edge.
               if (bus.SNAP) begin
                  state    <= HOLD;
                  cap_data <= {wrap_nxt, bus.Q_IN};
               end
            end
            default: begin
               if (bus.CAP_READY)
                  state <= IDLE;
            end
         endcase
      end
   end

`ifdef COUNT_STEP_CHECK_EN
   logic err;
   logic step_bad;

   assign step_bad = primed && (bus.Q_IN != q_s) && (bus.Q_IN != q_s + 3'd1);

   always_ff @(posedge CK) begin
      if (RST)
         err <= 1'b0;
      else if (step_bad)
         err <= 1'b1;
   end

   assign bus.ERR = err & VDD;
`else
   assign bus.ERR = 1'b0;
`endif

   // Outputs drive the supply level when high and ground otherwise.
   assign bus.TC        = tc_r & VDD;
   assign bus.WRAP_CNT  = VDD ? wrap_cnt : '0;
   assign bus.OVF       = ovf & VDD;
   assign bus.CAP_VALID = (state == HOLD) & VDD;
   assign bus.CAP_DATA  = VDD ? cap_data : '0;
endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: spec-level model checked every cycle plus literal pins.
// Honours COUNT_STEP_CHECK_EN the same way as the design.
module tb_count_wrap_monitor;
   localparam int WRAP_W = 5;
   localparam int TC_VAL = 7;
   localparam int MAXW   = (1 << WRAP_W) - 1;

   logic CK;
   logic RST;
   logic VDD;

   count_wrap_monitor_if #(.WRAP_W(WRAP_W)) bus ();

   count_wrap_monitor #(.WRAP_W(WRAP_W), .TC_VAL(TC_VAL)) dut (
      .CK  (CK),
      .RST (RST),
      .VDD (VDD),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // Spec-level model state
   int m_prev   = 0;
   bit m_primed = 0;
   int m_tc     = 0;
   int m_wrap   = 0;
   int m_ovf    = 0;
   int m_hold   = 0;
   int m_cap    = 0;
   int m_err    = 0;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int q, input bit snap = 1'b0, input bit rdy = 1'b0,
                       input bit rst = 1'b0);
      bus.Q_IN      = 3'(q);
      bus.SNAP      = snap;
      bus.CAP_READY = rdy;
      RST           = rst;
      @(posedge CK);
      if (rst) begin
         m_prev = 0; m_primed = 0; m_tc = 0; m_wrap = 0;
         m_ovf = 0; m_hold = 0; m_cap = 0; m_err = 0;
      end else begin
         m_tc = (m_primed && q == TC_VAL && m_prev != TC_VAL) ? 1 : 0;
         if (m_primed && m_prev == 7 && q == 0) begin
            if (m_wrap == MAXW) m_ovf = 1;
            else m_wrap = m_wrap + 1;
         end
`ifdef COUNT_STEP_CHECK_EN
         if (m_primed && q != m_prev && q != (m_prev + 1) % 8) m_err = 1;
`endif
         if (m_hold != 0) begin
            if (rdy) m_hold = 0;
         end else if (snap) begin
            m_hold = 1;
            m_cap  = m_wrap * 8 + q;
         end
         m_prev   = q;
         m_primed = 1;
      end
      #1;
   endtask

   task automatic wrap_once();
      for (int i = 1; i <= 7; i++) step(i);
      step(0);
   endtask

   always @(negedge CK) begin
      if (chk_en) begin
         chk("tc",        int'(bus.TC),        m_tc);
         chk("wrap_cnt",  int'(bus.WRAP_CNT),  m_wrap);
         chk("ovf",       int'(bus.OVF),       m_ovf);
         chk("cap_valid", int'(bus.CAP_VALID), m_hold);
         chk("cap_data",  int'(bus.CAP_DATA),  m_cap);
         chk("err",       int'(bus.ERR),       m_err);
      end
   end

   initial begin
      VDD = 1'b1;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk_en = 1;
      chk("rst_tc",    int'(bus.TC), 0);
      chk("rst_wrap",  int'(bus.WRAP_CNT), 0);
      chk("rst_valid", int'(bus.CAP_VALID), 0);
      chk("rst_data",  int'(bus.CAP_DATA), 0);

      // Count 0..7,0 then keep wrapping to saturation
      step(0);
      for (int i = 1; i <= 6; i++) step(i);
      chk("tc_before7", int'(bus.TC), 0);
      step(7);
      chk("tc_at7", int'(bus.TC), 1);
      step(0);
      chk("tc_after7", int'(bus.TC), 0);
      chk("wrap_first", int'(bus.WRAP_CNT), 1);
      chk("ovf_first", int'(bus.OVF), 0);
      for (int w = 2; w <= 33; w++) begin
         wrap_once();
         if (w == 31) begin
            chk("wrap_31", int'(bus.WRAP_CNT), 31);
            chk("ovf_31", int'(bus.OVF), 0);
         end
         if (w == 32) chk("ovf_32", int'(bus.OVF), 1);
         if (w == 33) begin
            chk("wrap_33", int'(bus.WRAP_CNT), 31);
            chk("ovf_33", int'(bus.OVF), 1);
         end
      end

      // Snapshot with WRAP_CNT=2, Q=3 held against back-pressure
      step(0, 0, 0, 1);
      step(0);
      wrap_once();
      wrap_once();
      step(1, 0, 1);
      step(2);
      step(3, 1);
      chk("snap_data", int'(bus.CAP_DATA), 19);
      chk("snap_valid", int'(bus.CAP_VALID), 1);
      for (int i = 0; i < 4; i++) begin
         step(3, 1, 0);
         chk("snap_hold", int'(bus.CAP_DATA), 19);
      end
      step(3, 0, 1);
      chk("snap_release", int'(bus.CAP_VALID), 0);
      chk("snap_keep", int'(bus.CAP_DATA), 19);

      // Snapshot on the wrap edge with WRAP_CNT=4
      step(0, 0, 0, 1);
      step(0);
      for (int w = 0; w < 4; w++) wrap_once();
      for (int i = 1; i <= 7; i++) step(i);
      step(0, 1);
      chk("wrap_snap", int'(bus.CAP_DATA), 40);
      chk("wrap_snap_cnt", int'(bus.WRAP_CNT), 5);
      wrap_once();
      chk("hold_wrap_cnt", int'(bus.WRAP_CNT), 6);
      chk("hold_wrap_data", int'(bus.CAP_DATA), 40);
      step(0, 1, 1);
      chk("snap_rdy_release", int'(bus.CAP_VALID), 0);
      step(0, 1, 0);
      chk("recapture_valid", int'(bus.CAP_VALID), 1);
      chk("recapture_data", int'(bus.CAP_DATA), 48);
      step(0, 0, 1);

      // Illegal step 2->5
      step(0, 0, 0, 1);
      step(0);
      step(1);
      step(2);
      step(5);
`ifdef COUNT_STEP_CHECK_EN
      chk("err_set", int'(bus.ERR), 1);
      step(6);
      chk("err_sticky", int'(bus.ERR), 1);
`else
      chk("err_off", int'(bus.ERR), 0);
      step(6);
      chk("err_off_sticky", int'(bus.ERR), 0);
`endif
      step(6, 0, 0, 1);
      chk("err_rst", int'(bus.ERR), 0);

      // Reset while holding a snapshot of Q=6
      step(0);
      for (int i = 1; i <= 7; i++) step(i);
      step(0);
      for (int i = 1; i <= 5; i++) step(i);
      step(6, 1);
      chk("pre_rst_valid", int'(bus.CAP_VALID), 1);
      step(6, 0, 0, 1);
      chk("rst_hold_valid", int'(bus.CAP_VALID), 0);
      chk("rst_hold_wrap", int'(bus.WRAP_CNT), 0);
      chk("rst_hold_tc", int'(bus.TC), 0);
      step(6);
      chk("post_rst_tc", int'(bus.TC), 0);
      chk("post_rst_err", int'(bus.ERR), 0);
      step(7);
      chk("post_rst_tc7", int'(bus.TC), 1);
      step(7);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
